// File: rtl/enet_rgmii_pkg.sv
// rtl/enet_rgmii_pkg.sv - shared speed codes, receive FSM encoding and preamble constants
//
// Shared definitions for the RGMII receive adapter:
//   SPD_*          : RGMII speed codes (11 is reserved and never acted on)
//   rx_state_e     : receive FSM state encoding
//   PREAMBLE_BYTE, SFD_BYTE, PRE_NIB, SFD_NIB : frame delimiter patterns
package enet_rgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [3:0] PRE_NIB       = 4'h5;
  localparam logic [3:0] SFD_NIB       = 4'hD;

endpackage

// File: rtl/enet_rgmii_inband_status.sv
// rtl/enet_rgmii_inband_status.sv - RGMII in-band link status decode with reserved-code filtering
//
// Captures link/speed/duplex from RXD during true inter-frame idle
// (RX_CTL low on both edges). False-carrier/extension cycles and updates
// carrying the reserved speed code are ignored as a whole.
//
// Ports:
//   i_clk, i_rst       : receive clock, asynchronous active-high reset
//   i_ctl_rise/fall    : RX_CTL sampled on rising/falling edge
//   i_rxd              : RXD sampled on the rising edge
//   o_link_up          : link status (RXD[0])
//   o_link_speed       : speed code (RXD[2:1])
//   o_full_duplex      : duplex (RXD[3])
module enet_rgmii_inband_status
  import enet_rgmii_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ctl_rise,
  input  logic       i_ctl_fall,
  input  logic [3:0] i_rxd,
  output logic       o_link_up,
  output logic [1:0] o_link_speed,
  output logic       o_full_duplex
);

  logic       w_upd;
  logic       r_link_up;
  logic [1:0] r_link_speed;
  logic       r_full_duplex;

  assign w_upd = ~i_ctl_rise & ~i_ctl_fall & (i_rxd[2:1] != SPD_RSVD);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_link_up     <= 1'b0;
      r_link_speed  <= SPD_10;
      r_full_duplex <= 1'b0;
    end else if (w_upd) begin
      r_link_up     <= i_rxd[0];
      r_link_speed  <= i_rxd[2:1];
      r_full_duplex <= i_rxd[3];
    end
  end

  assign o_link_up     = r_link_up;
  assign o_link_speed  = r_link_speed;
  assign o_full_duplex = r_full_duplex;

endmodule

// File: rtl/enet_rgmii_rx_adapter.sv
// rtl/enet_rgmii_rx_adapter.sv - RGMII receive adapter: SFD alignment, byte assembly, framed byte stream and statistics
//
// Sits behind the IDDR capture stage in the recovered RXC domain.
//
// Parameters:
//   INBAND_AUTO    : 1 = speed from in-band status, 0 = from speed_sel
//   STRIP_PREAMBLE : 1 = drop preamble/SFD, 0 = forward everything from DV
//   CNT_W          : statistics counter width
// Ports:
//   gmii_rx_clk, rst             : receive clock, asynchronous active-high reset
//   speed_sel                    : static speed select (INBAND_AUTO=0 only)
//   ddr_rxd_rise/fall            : RXD nibble per clock edge
//   ddr_ctl_rise/fall            : RX_CTL per clock edge (DV, DV^ER)
//   rx_valid/data/sof/eof/err    : framed byte stream to the MAC (no back-pressure)
//   link_up/link_speed/full_duplex : in-band status
//   frame_ok_cnt/frame_err_cnt   : saturating frame statistics
module enet_rgmii_rx_adapter
  import enet_rgmii_pkg::*;
#(
  parameter int INBAND_AUTO    = 1,
  parameter int STRIP_PREAMBLE = 1,
  parameter int CNT_W          = 16
) (
  input  logic             gmii_rx_clk,
  input  logic             rst,
  input  logic [1:0]       speed_sel,
  input  logic [3:0]       ddr_rxd_rise,
  input  logic [3:0]       ddr_rxd_fall,
  input  logic             ddr_ctl_rise,
  input  logic             ddr_ctl_fall,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_sof,
  output logic             rx_eof,
  output logic             rx_err,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             full_duplex,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  logic       w_dv;
  logic       w_er;
  logic [1:0] w_link_speed;
  logic [1:0] w_speed_now;
  logic       w_gig;
  logic [7:0] w_gig_byte;

  rx_state_e  r_state;
  logic [1:0] r_speed;
  logic       r_nib_phase;
  logic [3:0] r_nib_lo;
  logic       r_hold_vld;
  logic [7:0] r_hold_data;
  logic       r_sof_pend;
  logic       r_err_flag;

  logic       r_rx_valid;
  logic [7:0] r_rx_data;
  logic       r_rx_sof;
  logic       r_rx_eof;
  logic       r_rx_err;
  logic [CNT_W-1:0] r_ok_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  rx_state_e  w_nxt_state;
  logic [1:0] w_nxt_speed;
  logic       w_nxt_nib_phase;
  logic [3:0] w_nxt_nib_lo;
  logic       w_nxt_hold_vld;
  logic [7:0] w_nxt_hold_data;
  logic       w_nxt_sof_pend;
  logic       w_nxt_err_flag;
  logic       w_out_vld;
  logic [7:0] w_out_data;
  logic       w_out_sof;
  logic       w_out_eof;
  logic       w_out_err;
  logic       w_drop_evt;
  logic       w_inc_ok;
  logic       w_inc_err;

  enet_rgmii_inband_status u_inband (
    .i_clk         (gmii_rx_clk),
    .i_rst         (rst),
    .i_ctl_rise    (ddr_ctl_rise),
    .i_ctl_fall    (ddr_ctl_fall),
    .i_rxd         (ddr_rxd_rise),
    .o_link_up     (link_up),
    .o_link_speed  (w_link_speed),
    .o_full_duplex (full_duplex)
  );

  assign link_speed  = w_link_speed;
  assign w_dv        = ddr_ctl_rise;
  assign w_er        = ddr_ctl_rise ^ ddr_ctl_fall;
  assign w_speed_now = (INBAND_AUTO != 0) ? w_link_speed : speed_sel;
  assign w_gig_byte  = {ddr_rxd_fall, ddr_rxd_rise};

  // The IDLE-exit cycle already carries a unit, so it must use the live
  // speed; every later cycle of the frame uses the latched copy.
  assign w_gig = (r_state == IDLE) ? (w_speed_now == SPD_1000) : (r_speed == SPD_1000);

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_speed     = r_speed;
    w_nxt_nib_phase = r_nib_phase;
    w_nxt_nib_lo    = r_nib_lo;
    w_nxt_hold_vld  = 1'b0;
    w_nxt_hold_data = r_hold_data;
    w_nxt_sof_pend  = r_sof_pend;
    w_nxt_err_flag  = r_err_flag;
    w_out_vld       = 1'b0;
    w_out_data      = r_rx_data;
    w_out_sof       = 1'b0;
    w_out_eof       = 1'b0;
    w_out_err       = 1'b0;
    w_drop_evt      = 1'b0;

    // The held byte always drains the cycle after it was captured; DV in
    // that cycle tells whether more of the frame follows, which fixes eof.
    if (r_hold_vld) begin
      w_out_vld      = 1'b1;
      w_out_data     = r_hold_data;
      w_out_sof      = r_sof_pend;
      w_nxt_sof_pend = 1'b0;
      w_out_eof      = ~w_dv;
      w_out_err      = ~w_dv & r_err_flag;
    end

    unique case (r_state)
      IDLE: begin
        w_nxt_nib_phase = 1'b0;
        w_nxt_err_flag  = 1'b0;
        w_nxt_sof_pend  = 1'b1;
        if (w_dv) begin
          w_nxt_speed = w_speed_now;
          if (STRIP_PREAMBLE != 0) begin
            w_nxt_state = PRE;
          end else begin
            w_nxt_state    = DATA;
            w_nxt_err_flag = w_er;
            if (w_gig) begin
              w_nxt_hold_vld  = 1'b1;
              w_nxt_hold_data = w_gig_byte;
            end else begin
              w_nxt_nib_lo    = ddr_rxd_rise;
              w_nxt_nib_phase = 1'b1;
            end
          end
        end
      end

      PRE: begin
        if (!w_dv) begin
          w_nxt_state = IDLE;
        end else if (w_gig) begin
          if (w_gig_byte == SFD_BYTE) begin
            w_nxt_state = DATA;
          end else if (w_gig_byte != PREAMBLE_BYTE) begin
            w_nxt_state = DROP;
            w_drop_evt  = 1'b1;
          end
        end else begin
          if (ddr_rxd_rise == SFD_NIB) begin
            w_nxt_state     = DATA;
            w_nxt_nib_phase = 1'b0;
          end else if (ddr_rxd_rise != PRE_NIB) begin
            w_nxt_state = DROP;
            w_drop_evt  = 1'b1;
          end
        end
      end

      DATA: begin
        if (w_dv) begin
          w_nxt_err_flag = r_err_flag | w_er;
          if (w_gig) begin
            w_nxt_hold_vld  = 1'b1;
            w_nxt_hold_data = w_gig_byte;
          end else if (!r_nib_phase) begin
            w_nxt_nib_lo    = ddr_rxd_rise;
            w_nxt_nib_phase = 1'b1;
          end else begin
            w_nxt_hold_vld  = 1'b1;
            w_nxt_hold_data = {ddr_rxd_rise, r_nib_lo};
            w_nxt_nib_phase = 1'b0;
          end
        end else begin
          w_nxt_state     = IDLE;
          w_nxt_nib_phase = 1'b0;
          // A dangling low nibble can only exist with the hold empty, so
          // the truncated byte takes the output slot directly.
          if (!r_hold_vld && !w_gig && r_nib_phase) begin
            w_out_vld  = 1'b1;
            w_out_data = {4'h0, r_nib_lo};
            w_out_sof  = r_sof_pend;
            w_out_eof  = 1'b1;
            w_out_err  = 1'b1;
          end
        end
      end

      DROP: begin
        if (!w_dv) begin
          w_nxt_state = IDLE;
        end
      end
    endcase
  end

  assign w_inc_ok  = w_out_eof & ~w_out_err;
  assign w_inc_err = (w_out_eof & w_out_err) | w_drop_evt;

  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_speed     <= SPD_10;
      r_nib_phase <= 1'b0;
      r_nib_lo    <= 4'h0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= 8'h00;
      r_sof_pend  <= 1'b0;
      r_err_flag  <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_sof    <= 1'b0;
      r_rx_eof    <= 1'b0;
      r_rx_err    <= 1'b0;
      r_ok_cnt    <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_speed     <= w_nxt_speed;
      r_nib_phase <= w_nxt_nib_phase;
      r_nib_lo    <= w_nxt_nib_lo;
      r_hold_vld  <= w_nxt_hold_vld;
      r_hold_data <= w_nxt_hold_data;
      r_sof_pend  <= w_nxt_sof_pend;
      r_err_flag  <= w_nxt_err_flag;
      r_rx_valid  <= w_out_vld;
      r_rx_data   <= w_out_data;
      r_rx_sof    <= w_out_sof;
      r_rx_eof    <= w_out_eof;
      r_rx_err    <= w_out_err;
      if (w_inc_ok && !(&r_ok_cnt)) begin
        r_ok_cnt <= r_ok_cnt + CNT_W'(1);
      end
      if (w_inc_err && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
    end
  end

  assign rx_valid      = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign rx_sof        = r_rx_sof;
  assign rx_eof        = r_rx_eof;
  assign rx_err        = r_rx_err;
  assign frame_ok_cnt  = r_ok_cnt;
  assign frame_err_cnt = r_err_cnt;

endmodule
